// File: rtl/fft_pkg.sv
// Shared widths and rounding/saturation helpers for the FFT butterfly datapath.
// Helpers work on a 64-bit signed carrier so any configured width can use them.
package fft_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 15;
    localparam int DEF_TWID_WIDTH = DEF_FRAC_BITS + 2;

    // Clamp x to the signed range of a w-bit value; result stays sign-extended.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Round half up, then drop f fractional bits.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] x, input int f);
        return (x + (64'sd1 <<< (f - 1))) >>> f;
    endfunction

endpackage

// File: rtl/cplx_mult_rnd.sv
// Combinational complex multiply b*W with round-half-up and saturation back to
// the sample width.
module cplx_mult_rnd
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    localparam int TWID_WIDTH = FRAC_BITS + 2
) (
    input  logic signed [DATA_WIDTH-1:0] b_re,
    input  logic signed [DATA_WIDTH-1:0] b_im,
    input  logic signed [TWID_WIDTH-1:0] w_re,
    input  logic signed [TWID_WIDTH-1:0] w_im,
    output logic signed [DATA_WIDTH-1:0] rot_re,
    output logic signed [DATA_WIDTH-1:0] rot_im
);

    localparam int PROD_W = DATA_WIDTH + TWID_WIDTH;
    localparam int ACC_W  = PROD_W + 1;

    logic signed [PROD_W-1:0] p_rr;
    logic signed [PROD_W-1:0] p_ii;
    logic signed [PROD_W-1:0] p_ri;
    logic signed [PROD_W-1:0] p_ir;
    logic signed [ACC_W-1:0]  acc_re;
    logic signed [ACC_W-1:0]  acc_im;

    assign p_rr = PROD_W'(b_re) * PROD_W'(w_re);
    assign p_ii = PROD_W'(b_im) * PROD_W'(w_im);
    assign p_ri = PROD_W'(b_re) * PROD_W'(w_im);
    assign p_ir = PROD_W'(b_im) * PROD_W'(w_re);

    assign acc_re = ACC_W'(p_rr) - ACC_W'(p_ii);
    assign acc_im = ACC_W'(p_ri) + ACC_W'(p_ir);

    // (-1.0)*(-1.0) lands at +1.0, which the Q1 sample range cannot hold.
    assign rot_re = DATA_WIDTH'(sat_s(round_shift(64'(acc_re), FRAC_BITS), DATA_WIDTH));
    assign rot_im = DATA_WIDTH'(sat_s(round_shift(64'(acc_im), FRAC_BITS), DATA_WIDTH));

endmodule

// File: rtl/fft_butterfly_comb.sv
// Radix-2 DIT butterfly: a_o = a + b*W, b_o = a - b*W, saturated, one register
// stage. Data loads every cycle; consumers qualify it with valid_o.
module fft_butterfly_comb
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    localparam int TWID_WIDTH = FRAC_BITS + 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                valid_i,
    input  logic signed [1:0][TWID_WIDTH-1:0]   twid_i,
    input  logic signed [1:0][DATA_WIDTH-1:0]   a_i,
    input  logic signed [1:0][DATA_WIDTH-1:0]   b_i,
    output logic                                valid_o,
    output logic signed [1:0][DATA_WIDTH-1:0]   a_o,
    output logic signed [1:0][DATA_WIDTH-1:0]   b_o
);

    logic signed [DATA_WIDTH-1:0] b_rot_re;
    logic signed [DATA_WIDTH-1:0] b_rot_im;

    logic signed [DATA_WIDTH-1:0] a_part [2];
    logic signed [DATA_WIDTH-1:0] rot    [2];
    logic signed [DATA_WIDTH:0]   sum    [2];
    logic signed [DATA_WIDTH:0]   dif    [2];
    logic [1:0][DATA_WIDTH-1:0]   a_nxt;
    logic [1:0][DATA_WIDTH-1:0]   b_nxt;

    cplx_mult_rnd #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mult (
        .b_re   ($signed(b_i[0])),
        .b_im   ($signed(b_i[1])),
        .w_re   ($signed(twid_i[0])),
        .w_im   ($signed(twid_i[1])),
        .rot_re (b_rot_re),
        .rot_im (b_rot_im)
    );

    always_comb begin
        rot[0] = b_rot_re;
        rot[1] = b_rot_im;
        a_nxt  = '0;
        b_nxt  = '0;
        for (int p = 0; p < 2; p++) begin
            a_part[p] = $signed(a_i[p]);
            sum[p]    = (DATA_WIDTH+1)'(a_part[p]) + (DATA_WIDTH+1)'(rot[p]);
            dif[p]    = (DATA_WIDTH+1)'(a_part[p]) - (DATA_WIDTH+1)'(rot[p]);
            a_nxt[p]  = DATA_WIDTH'(sat_s(64'(sum[p]), DATA_WIDTH));
            b_nxt[p]  = DATA_WIDTH'(sat_s(64'(dif[p]), DATA_WIDTH));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            a_o     <= '0;
            b_o     <= '0;
        end else begin
            valid_o <= valid_i;
            a_o     <= a_nxt;
            b_o     <= b_nxt;
        end
    end

endmodule

// File: tb/tb_fft_butterfly_comb.sv
// Self-checking bench for fft_butterfly_comb: fixed vector table, random vectors
// against an arithmetic model, back-to-back valid stream and async reset cases.
module tb_fft_butterfly_comb;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 valid_i;
    logic [1:0][16:0]     twid_i;
    logic [1:0][15:0]     a_i;
    logic [1:0][15:0]     b_i;
    logic                 valid_o;
    logic [1:0][15:0]     a_o;
    logic [1:0][15:0]     b_o;

    fft_butterfly_comb dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .twid_i  (twid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .a_o     (a_o),
        .b_o     (b_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int valid;
        int w_re, w_im, a_re, a_im, b_re, b_im;
        int r_re, r_im, ao_re, ao_im, bo_re, bo_im;
    } vec_t;

    typedef struct {
        int valid;
        int ao_re, ao_im, bo_re, bo_im;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   vo_count;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int sat16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    function automatic vec_t model(input int v, input int w_re, input int w_im,
                                   input int a_re, input int a_im,
                                   input int b_re, input int b_im);
        vec_t   r;
        longint pre, pim;
        pre = longint'(b_re) * w_re - longint'(b_im) * w_im;
        pim = longint'(b_re) * w_im + longint'(b_im) * w_re;
        r.valid = v;
        r.w_re = w_re; r.w_im = w_im;
        r.a_re = a_re; r.a_im = a_im;
        r.b_re = b_re; r.b_im = b_im;
        r.r_re  = sat16((pre + 16384) >>> 15);
        r.r_im  = sat16((pim + 16384) >>> 15);
        r.ao_re = sat16(longint'(a_re) + r.r_re);
        r.ao_im = sat16(longint'(a_im) + r.r_im);
        r.bo_re = sat16(longint'(a_re) - r.r_re);
        r.bo_im = sat16(longint'(a_im) - r.r_im);
        return r;
    endfunction

    task automatic drive(input vec_t v);
        valid_i   = (v.valid != 0);
        twid_i[0] = 17'(v.w_re);
        twid_i[1] = 17'(v.w_im);
        a_i[0]    = 16'(v.a_re);
        a_i[1]    = 16'(v.a_im);
        b_i[0]    = 16'(v.b_re);
        b_i[1]    = 16'(v.b_im);
    endtask

    // Drive on the falling edge, check b_rot combinationally, check the
    // registered result just after the following rising edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk_i);
        drive(v);
        e.valid = v.valid;
        e.ao_re = v.ao_re; e.ao_im = v.ao_im;
        e.bo_re = v.bo_re; e.bo_im = v.bo_im;
        sb.push_back(e);
        #1;
        chk({tag, " b_rot_re"}, int'(dut.b_rot_re), v.r_re);
        chk({tag, " b_rot_im"}, int'(dut.b_rot_im), v.r_im);
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, " valid_o"}, int'(valid_o), e.valid);
            chk({tag, " a_o re"}, int'($signed(a_o[0])), e.ao_re);
            chk({tag, " a_o im"}, int'($signed(a_o[1])), e.ao_im);
            chk({tag, " b_o re"}, int'($signed(b_o[0])), e.bo_re);
            chk({tag, " b_o im"}, int'($signed(b_o[1])), e.bo_im);
        end
        if (valid_o) vo_count++;
    endtask

    vec_t tbl[6];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // valid, W, a, b, b_rot, a_o, b_o
        tbl[0] = '{1, 32768, 0,      16384, 0,      8192, 0,       8192, 0,       24576, 0,      8192, 0};
        tbl[1] = '{1, 23170, -23170, 16384, 0,      16384, 0,      11585, -11585, 27969, -11585, 4799, 11585};
        tbl[2] = '{1, 0, -32768,     16384, 8192,   8192, -8192,   -8192, -8192,  8192, 0,       24576, 16384};
        tbl[3] = '{1, 32768, 0,      32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768, 0, 0};
        tbl[4] = '{1, -32768, 0,     0, 0,          -32768, 0,     32767, 0,      32767, 0,      -32767, 0};
        tbl[5] = '{0, 32768, 0,      100, -200,     -300, 400,     -300, 400,     -200, 200,     400, -600};

        vo_count = 0;
        rst_ni   = 1'b0;
        drive(model(0, 0, 0, 0, 0, 0, 0));
        #3;
        chk("reset valid_o", int'(valid_o), 0);
        chk("reset a_o", int'(a_o), 0);
        chk("reset b_o", int'(b_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) step(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 24; i++) begin
            step(model(int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 131071)) - 65536,
                       int'($urandom_range(0, 131071)) - 65536,
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768),
                 $sformatf("rnd%0d", i));
        end

        // Back-to-back stream: three valid samples then an idle cycle.
        step(model(0, 32768, 0, 1, 2, 3, 4), "pre_stream");
        vo_count = 0;
        step(model(1, 32768, 0, 1000, 2000, 300, 400), "stream0");
        step(model(1, 0, 32768, -500, 700, 1200, -900), "stream1");
        step(model(1, 23170, 23170, 4000, -4000, 8000, 6000), "stream2");
        step(model(0, 32768, 0, 5, 6, 7, 8), "stream_idle");
        chk("stream valid_o count", vo_count, 3);

        // Asynchronous reset between edges with nonzero registered outputs.
        step(tbl[0], "pre_reset");
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async rst valid_o", int'(valid_o), 0);
        chk("async rst a_o", int'(a_o), 0);
        chk("async rst b_o", int'(b_o), 0);
        @(negedge clk_i);
        drive(tbl[1]);
        @(posedge clk_i);
        #1;
        chk("held rst valid_o", int'(valid_o), 0);
        chk("held rst a_o", int'(a_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(model(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk_i);
        #1;
        chk("dropped sample valid_o", int'(valid_o), 0);
        step(tbl[2], "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_butterfly_comb.md
Name: fft_butterfly_comb

Overview:
Radix-2 decimation-in-time FFT butterfly on complex fixed-point samples.
- Rotates b by twiddle W, then forms a+bW and a−bW.
- Complex datapath with one output register stage and a valid flag.
- Instantiated once per butterfly slot in the FFT stage pipeline.

Parameters:
DATA_WIDTH, 16, sample width per real/imag part; signed Q1.(FRAC_BITS).
FRAC_BITS, 15, fractional bits for data and twiddle.
TWID_WIDTH (localparam), FRAC_BITS+2 = 17, twiddle width per part; signed Q2.15 so +1.0 (0x08000) is exact.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous active-low reset.
valid_i  in  1  input sample qualifier.
twid_i  in  [1:0][TWID_WIDTH-1:0] signed  twiddle; [0]=Re, [1]=Im.
a_i  in  [1:0][DATA_WIDTH-1:0] signed  upper input; [0]=Re, [1]=Im.
b_i  in  [1:0][DATA_WIDTH-1:0] signed  lower input; [0]=Re, [1]=Im.
valid_o  out  1  output qualifier.
a_o  out  [1:0][DATA_WIDTH-1:0] signed  a + b·W.
b_o  out  [1:0][DATA_WIDTH-1:0] signed  a − b·W.

Behaviour:
- Internal combinational signals b_rot_re and b_rot_im (DATA_WIDTH, signed) are required names so benches can probe them hierarchically.
- Complex product:
  - re = b0·W0 − b1·W1; im = b0·W1 + b1·W0.
  - Full precision: 33-bit products, 34-bit sums.
- Rounding of the product:
  - Add 2^(FRAC_BITS−1), then arithmetic shift right by FRAC_BITS (round half up).
  - Saturate to DATA_WIDTH: clamp to 0x7FFF / 0x8000.
  - Result drives b_rot_re and b_rot_im.
- Sum and difference:
  - a_o = a + b_rot and b_o = a − b_rot, per part, computed in DATA_WIDTH+1 bits.
  - Saturate to DATA_WIDTH. No 1/2 scaling; stage scaling is the caller's job.
- Timing:
  - Outputs registered on rising clk_i; latency exactly 1 cycle.
  - valid_o = valid_i delayed 1 cycle.
  - Data registers load every cycle regardless of valid_i; downstream consumers qualify data with valid_o.
- Reset:
  - rst_ni low clears a_o, b_o and valid_o to 0 immediately, independent of the clock.
  - First capture happens on the first rising edge after deassertion.
  - Reset asserted mid-stream drops the in-flight sample.
- Boundaries:
  - W=+1.0 is exact (b_rot = b).
  - b=−1.0 with W=−1.0 saturates b_rot to 0x7FFF.
  - No internal state beyond the single register stage; back-to-back valid samples are supported every cycle.

Decomposition:
- Shared package fft_pkg holds DATA_WIDTH, FRAC_BITS and TWID_WIDTH defaults, plus a sat/round helper function.
- One natural sub-module: cplx_mult_rnd, the combinational complex multiply with rounding and saturation, producing b_rot.
- The add/sub and output register stay in the top.

Test Plan:
1. W=(0x08000,0), a=(0x4000,0), b=(0x2000,0), valid_i=1 → next cycle: b_rot=(0x2000,0), a_o=(0x6000,0), b_o=(0x2000,0), valid_o=1.
2. W=(23170,−23170), a=(0x4000,0), b=(0x4000,0) → b_rot=(11585,−11585), a_o=(27969,−11585), b_o=(4799,11585).
3. W=(0,−32768), a=(0x4000,0x2000), b=(0x2000,−0x2000) → b_rot=(−0x2000,−0x2000), a_o=(0x2000,0), b_o=(0x6000,0x4000).
4. Saturation, two sub-cases:
   - W=+1.0, a=b=(0x7FFF,0x8000) → a_o=(0x7FFF,0x8000), b_o=(0,0).
   - W=(−32768,0), b=(0x8000,0) → b_rot_re=0x7FFF.
5. Drive valid_i=1 for 3 consecutive cycles with distinct data → valid_o high for exactly 3 cycles, each output 1 cycle after its input.
6. Pull rst_ni low between clock edges while outputs are nonzero → a_o, b_o and valid_o read 0 before the next edge; normal capture resumes on the first edge after release.
